// File: rtl/baseline_subtract_l4_pkg.sv
// Shared types, widths and arithmetic helpers for the L4 baseline subtractor.
// Baseline math runs at INTERNAL_WIDTH+1 bits and is only narrowed at saturation.
package baseline_subtract_l4_pkg;

   localparam int DATA_WIDTH     = 16;
   localparam int INTERNAL_WIDTH = 48;
   localparam int LANES          = 16;
   localparam int BL_WIDTH       = INTERNAL_WIDTH + 1;
   localparam int PROD_WIDTH     = BL_WIDTH + 4;
   localparam int DIFF_WIDTH     = BL_WIDTH + 1;

   localparam logic signed [DIFF_WIDTH-1:0] SAT_MAX = DIFF_WIDTH'(2**(DATA_WIDTH-1) - 1);
   localparam logic signed [DIFF_WIDTH-1:0] SAT_MIN = DIFF_WIDTH'(-(2**(DATA_WIDTH-1)));

   typedef logic signed [DATA_WIDTH-1:0] sample_t;
   typedef sample_t [LANES-1:0]          frame_t;
   typedef logic signed [BL_WIDTH-1:0]   bl_t;

   typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_RUN} state_t;

   typedef struct packed {
      state_t      state;
      logic [7:0]  skip_cnt;
      logic [15:0] occupancy;
   } dbg_t;

   // floor(delta*k/16) built from shifted copies of delta; k is a per-lane constant
   function automatic bl_t interp_step(bl_t delta, int k);
      logic signed [PROD_WIDTH-1:0] acc;
      logic signed [PROD_WIDTH-1:0] d;
      acc = '0;
      d   = PROD_WIDTH'(delta);
      for (int b = 0; b < 4; b++) begin
         if (k[b]) acc = acc + (d <<< b);
      end
      return bl_t'(acc >>> 4);
   endfunction

   function automatic sample_t sat_sample(logic signed [DIFF_WIDTH-1:0] x);
      if (x > SAT_MAX) return sample_t'(SAT_MAX);
      if (x < SAT_MIN) return sample_t'(SAT_MIN);
      return sample_t'(x);
   endfunction

endpackage

// File: rtl/baseline_subtract_l4_if.sv
// Bundle of raw-frame, approximation and corrected-frame signals plus debug state.
// Handshake: every *valid is a single-cycle strobe with no ready; data is meaningful only while its valid is high.
interface baseline_subtract_l4_if;
   import baseline_subtract_l4_pkg::*;

   logic                             din_valid;
   frame_t                           din;
   logic                             a4_valid;
   logic signed [INTERNAL_WIDTH-1:0] a4_0;
   logic                             dout_valid;
   frame_t                           dout;
   logic                             fifo_ovf;
   logic                             fifo_unf;
   dbg_t                             dbg;

   modport master (
      output din_valid, din, a4_valid, a4_0,
      input  dout_valid, dout, fifo_ovf, fifo_unf, dbg
   );

   modport slave (
      input  din_valid, din, a4_valid, a4_0,
      output dout_valid, dout, fifo_ovf, fifo_unf, dbg
   );
endinterface

// File: rtl/baseline_subtract_l4_frame_fifo.sv
// Single-clock frame FIFO with registered read; pushes while full and pops while empty are ignored.
module baseline_subtract_l4_frame_fifo
   import baseline_subtract_l4_pkg::*;
#(
   parameter int DEPTH = 32,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  frame_t        wr_data_i,
   input  logic          pop_i,
   output frame_t        rd_data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   count_o
);

   frame_t        mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   frame_t        rd_data_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rd_data_o = rd_data_q;

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop) begin
            rd_data_q <= mem_q[rd_ptr_q];
            rd_ptr_q  <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/baseline_subtract_l4.sv
// Buffers raw 16-lane frames, aligns them to L4 approximation samples and subtracts
// a held or lane-interpolated baseline through a 3-stage pipeline.
module baseline_subtract_l4
   import baseline_subtract_l4_pkg::*;
#(
   parameter int A4_SHIFT     = 2,
   parameter int ALIGN_FRAMES = 2,
   parameter int FIFO_DEPTH   = 32,
   parameter int INTERP       = 1,
   localparam int AW          = $clog2(FIFO_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   baseline_subtract_l4_if.slave bus_io
);

   state_t      state_q, state_d;
   logic [7:0]  skip_cnt_q, skip_cnt_d;
   bl_t         prev_bl_q, prev_bl_d;
   logic        ovf_q, unf_q;
   logic        skip_en, run_en, first_hold;

   frame_t      fifo_rd;
   logic        fifo_full, fifo_empty;
   logic [AW:0] fifo_count;
   logic        pop;
   bl_t         cur_bl, prev_sel;

   logic        s1_valid_q, s2_valid_q, dout_valid_q;
   bl_t         s1_prev_q, s1_cur_q, s1_delta_q;
   bl_t         bl_d [LANES];
   bl_t         s2_bl_q [LANES];
   frame_t      s2_frame_q, dout_q;
   logic signed [DIFF_WIDTH-1:0] diff [LANES];

   baseline_subtract_l4_frame_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (bus_io.din_valid),
      .wr_data_i (bus_io.din),
      .pop_i     (pop),
      .rd_data_o (fifo_rd),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

   assign cur_bl   = bl_t'(bus_io.a4_0 >>> A4_SHIFT);
   assign pop      = run_en && !fifo_empty;
   // Without warm-up the very first baseline has no predecessor, so it is held flat.
   assign prev_sel = first_hold ? cur_bl : prev_bl_q;

   always_comb begin
      state_d    = state_q;
      skip_cnt_d = skip_cnt_q;
      case (state_q)
         ST_IDLE: if (bus_io.a4_valid) begin
            if (ALIGN_FRAMES == 0) begin
               state_d = ST_RUN;
            end else begin
               skip_cnt_d = 8'd1;
               state_d    = (ALIGN_FRAMES == 1) ? ST_RUN : ST_WARMUP;
            end
         end
         ST_WARMUP: if (bus_io.a4_valid) begin
            skip_cnt_d = skip_cnt_q + 8'd1;
            if (skip_cnt_q + 8'd1 == 8'(ALIGN_FRAMES)) state_d = ST_RUN;
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      skip_en    = 1'b0;
      run_en     = 1'b0;
      first_hold = 1'b0;
      case (state_q)
         ST_IDLE: if (bus_io.a4_valid) begin
            if (ALIGN_FRAMES == 0) begin
               run_en     = 1'b1;
               first_hold = 1'b1;
            end else begin
               skip_en = 1'b1;
            end
         end
         ST_WARMUP: skip_en = bus_io.a4_valid;
         ST_RUN:    run_en  = bus_io.a4_valid;
         default:   run_en  = 1'b0;
      endcase
   end

   always_comb begin
      prev_bl_d = prev_bl_q;
      if (skip_en || pop) prev_bl_d = cur_bl;
   end

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         bl_d[k] = (INTERP != 0) ? (s1_prev_q + interp_step(s1_delta_q, k)) : s1_cur_q;
         diff[k] = DIFF_WIDTH'($signed(s2_frame_q[k])) - DIFF_WIDTH'(s2_bl_q[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         skip_cnt_q   <= '0;
         prev_bl_q    <= '0;
         ovf_q        <= 1'b0;
         unf_q        <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_prev_q    <= '0;
         s1_cur_q     <= '0;
         s1_delta_q   <= '0;
         s2_valid_q   <= 1'b0;
         s2_frame_q   <= '0;
         dout_valid_q <= 1'b0;
         dout_q       <= '0;
         for (int k = 0; k < LANES; k++) s2_bl_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         skip_cnt_q <= skip_cnt_d;
         prev_bl_q  <= prev_bl_d;
         ovf_q      <= ovf_q | (bus_io.din_valid & fifo_full);
         unf_q      <= unf_q | (run_en & fifo_empty);

         s1_valid_q <= pop;
         if (pop) begin
            s1_prev_q  <= prev_sel;
            s1_cur_q   <= cur_bl;
            s1_delta_q <= cur_bl - prev_sel;
         end

         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_frame_q <= fifo_rd;
            for (int k = 0; k < LANES; k++) s2_bl_q[k] <= bl_d[k];
         end

         dout_valid_q <= s2_valid_q;
         if (s2_valid_q) begin
            for (int k = 0; k < LANES; k++) dout_q[k] <= sat_sample(diff[k]);
         end
      end
   end

   assign bus_io.dout_valid = dout_valid_q;
   assign bus_io.dout       = dout_q;
   assign bus_io.fifo_ovf   = ovf_q;
   assign bus_io.fifo_unf   = unf_q;
   assign bus_io.dbg        = '{state: state_q, skip_cnt: skip_cnt_q, occupancy: 16'(fifo_count)};

endmodule
